// File: rtl/frame_reader_pkg.sv
// Shared frame layout constants and reader state encoding; the packet writer
// imports the same package so both sides agree on the buffer format.
package frame_reader_pkg;

    localparam int WORD_W = 32;

    localparam logic [31:0] FRAME_ID_WORD   = 32'hC623_0121;
    localparam int          FRAME_SUM_ADDR  = 4;
    localparam int          FRAME_DATA_BASE = 16;

    // Summary word: num[31:24], zero[23:21], mode[20:17], orientation[16:0]
    localparam int NUM_MSB    = 31;
    localparam int NUM_LSB    = 24;
    localparam int MODE_MSB   = 20;
    localparam int MODE_LSB   = 17;
    localparam int ORIENT_MSB = 16;
    localparam int ORIENT_LSB = 0;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 4'd0,
        ST_RD_ID   = 4'd1,
        ST_RD_SUM  = 4'd2,
        ST_CHECK   = 4'd3,
        ST_TX_ID   = 4'd4,
        ST_TX_SUM  = 4'd5,
        ST_RD_DATA = 4'd6,
        ST_TX_DATA = 4'd7,
        ST_DONE    = 4'd8
    } state_t;

endpackage

// File: rtl/frame_reader_if.sv
// Buffer read port plus AXI-Stream master bundle of the frame reader.
interface frame_reader_if
    import frame_reader_pkg::*;
#(
    parameter int ADDR_W = 15
);
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_rdata;
    logic [WORD_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;

    modport master (
        output mem_en, mem_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  mem_rdata, m_axis_tready
    );

    modport slave (
        input  mem_en, mem_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output mem_rdata, m_axis_tready
    );
endinterface

// File: rtl/frame_reader_mem_read_port.sv
// Single-outstanding buffer read: one-cycle mem_en pulse, latency countdown,
// then rdata is presented together with a one-cycle rvalid.
module frame_reader_mem_read_port
    import frame_reader_pkg::*;
#(
    parameter int ADDR_W     = 15,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              rvalid,
    output logic [WORD_W-1:0] rdata
);
    localparam logic [1:0] LAT = 2'(RD_LATENCY);

    logic       pending;
    logic [1:0] lat_cnt;

    // start is ignored while a read is pending, so a requester may hold it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en   <= 1'b0;
            mem_addr <= '0;
            pending  <= 1'b0;
            lat_cnt  <= '0;
        end else begin
            mem_en <= 1'b0;
            if (start && !pending) begin
                mem_en   <= 1'b1;
                mem_addr <= addr;
                pending  <= 1'b1;
                lat_cnt  <= LAT;
            end else if (pending) begin
                if (lat_cnt == 2'd0) begin
                    pending <= 1'b0;
                end else begin
                    lat_cnt <= lat_cnt - 2'd1;
                end
            end
        end
    end

    assign rvalid = pending && (lat_cnt == 2'd0);
    assign rdata  = mem_rdata;

endmodule

// File: rtl/frame_reader.sv
// Frame reader: on a trigger edge fetches ID, summary and data words from the
// capture buffer, validates the ID and streams the frame out over AXI-Stream.
module frame_reader
    import frame_reader_pkg::*;
#(
    parameter int          ADDR_W     = 15,
    parameter int          RD_LATENCY = 1,
    parameter logic [31:0] ID_WORD    = FRAME_ID_WORD,
    parameter int          SUM_ADDR   = FRAME_SUM_ADDR,
    parameter int          DATA_BASE  = FRAME_DATA_BASE,
    parameter int          MAX_WORDS  = 255
) (
    input  logic           aclk,
    input  logic           rst,
    input  logic           trigger,
    frame_reader_if.master bus,
    output logic           busy,
    output logic           frame_done,
    output logic           id_error,
    output logic [7:0]     word_count
);
    localparam logic [7:0] MAX_N = (MAX_WORDS > 255) ? 8'd255 : 8'(MAX_WORDS);

    function automatic logic [7:0] clamp_count(input logic [7:0] num);
        return (num > MAX_N) ? MAX_N : num;
    endfunction

    state_t state, state_nx;

    logic              trig_d;
    logic              trig_edge;
    logic [WORD_W-1:0] id_reg;
    logic [WORD_W-1:0] sum_reg;
    logic [WORD_W-1:0] data_reg;
    logic [7:0]        n_reg;
    logic [7:0]        k_reg;
    logic              last_data;

    logic              rd_start;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [WORD_W-1:0] rd_data;

    logic              tvalid;
    logic              tlast;
    logic [WORD_W-1:0] tdata;

    assign trig_edge = trigger & ~trig_d;
    assign last_data = (k_reg == n_reg - 8'd1);

    frame_reader_mem_read_port #(
        .ADDR_W     (ADDR_W),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_port (
        .clk       (aclk),
        .rst       (rst),
        .start     (rd_start),
        .addr      (rd_addr),
        .mem_en    (bus.mem_en),
        .mem_addr  (bus.mem_addr),
        .mem_rdata (bus.mem_rdata),
        .rvalid    (rd_valid),
        .rdata     (rd_data)
    );

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (trig_edge) state_nx = ST_RD_ID;
            ST_RD_ID:   if (rd_valid) state_nx = ST_RD_SUM;
            ST_RD_SUM:  if (rd_valid) state_nx = ST_CHECK;
            ST_CHECK:   state_nx = (id_reg != ID_WORD) ? ST_DONE : ST_TX_ID;
            ST_TX_ID:   if (bus.m_axis_tready) state_nx = ST_TX_SUM;
            ST_TX_SUM:  if (bus.m_axis_tready) state_nx = (n_reg == 8'd0) ? ST_DONE : ST_RD_DATA;
            ST_RD_DATA: if (rd_valid) state_nx = ST_TX_DATA;
            ST_TX_DATA: if (bus.m_axis_tready) state_nx = last_data ? ST_DONE : ST_RD_DATA;
            ST_DONE:    state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Stream outputs are decoded from state and held registers only, so they
    // stay stable through a stall and vanish the moment reset hits.
    always_comb begin
        rd_start   = 1'b0;
        rd_addr    = '0;
        tvalid     = 1'b0;
        tlast      = 1'b0;
        tdata      = '0;
        frame_done = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_RD_ID: begin
                rd_start = 1'b1;
            end
            ST_RD_SUM: begin
                rd_start = 1'b1;
                rd_addr  = ADDR_W'(SUM_ADDR);
            end
            ST_RD_DATA: begin
                rd_start = 1'b1;
                rd_addr  = ADDR_W'(DATA_BASE) + ADDR_W'({k_reg, 2'b00});
            end
            ST_TX_ID: begin
                tvalid = 1'b1;
                tdata  = id_reg;
            end
            ST_TX_SUM: begin
                tvalid = 1'b1;
                tdata  = sum_reg;
                tlast  = (n_reg == 8'd0);
            end
            ST_TX_DATA: begin
                tvalid = 1'b1;
                tdata  = data_reg;
                tlast  = last_data;
            end
            ST_DONE: begin
                frame_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            trig_d     <= 1'b0;
            id_reg     <= '0;
            sum_reg    <= '0;
            data_reg   <= '0;
            n_reg      <= '0;
            k_reg      <= '0;
            id_error   <= 1'b0;
            word_count <= '0;
        end else begin
            trig_d <= trigger;
            case (state)
                ST_IDLE:    if (trig_edge) id_error <= 1'b0;
                ST_RD_ID:   if (rd_valid) id_reg <= rd_data;
                ST_RD_SUM:  if (rd_valid) sum_reg <= rd_data;
                ST_CHECK: begin
                    if (id_reg != ID_WORD) begin
                        id_error <= 1'b1;
                    end else begin
                        n_reg      <= clamp_count(sum_reg[NUM_MSB:NUM_LSB]);
                        word_count <= clamp_count(sum_reg[NUM_MSB:NUM_LSB]);
                    end
                end
                ST_TX_SUM:  if (bus.m_axis_tready) k_reg <= 8'd0;
                ST_RD_DATA: if (rd_valid) data_reg <= rd_data;
                ST_TX_DATA: if (bus.m_axis_tready && !last_data) k_reg <= k_reg + 8'd1;
                default: ;
            endcase
        end
    end

    assign bus.m_axis_tvalid = tvalid;
    assign bus.m_axis_tlast  = tlast;
    assign bus.m_axis_tdata  = tdata;

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader: buffer model with 2-cycle read latency,
// stream/read-port monitors and hand-computed expected frames.
module tb_frame_reader;
    import frame_reader_pkg::*;

    localparam int ADDR_W = 15;
    localparam int RD_LAT = 2;

    localparam logic [31:0] GOOD_ID = 32'hC623_0121;
    localparam logic [31:0] BAD_ID  = 32'hDEAD_BEEF;
    localparam logic [31:0] SUM3    = 32'h030A_1234;
    localparam logic [31:0] SUM0    = 32'h0002_0001;
    localparam logic [31:0] D0      = 32'h0000_00A1;
    localparam logic [31:0] D1      = 32'h0000_00B2;
    localparam logic [31:0] D2      = 32'h0000_00C3;

    logic       aclk = 1'b0;
    logic       rst;
    logic       trigger;
    logic       busy;
    logic       frame_done;
    logic       id_error;
    logic [7:0] word_count;

    frame_reader_if #(.ADDR_W(ADDR_W)) bus ();

    frame_reader #(
        .ADDR_W     (ADDR_W),
        .RD_LATENCY (RD_LAT)
    ) dut (
        .aclk       (aclk),
        .rst        (rst),
        .trigger    (trigger),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .id_error   (id_error),
        .word_count (word_count)
    );

    always #5 aclk = ~aclk;

    logic [31:0] mem [0:8191];
    logic [31:0] rd_q1 = '0;
    logic [31:0] rd_q2 = '0;

    always @(posedge aclk) begin
        if (bus.mem_en) rd_q1 <= mem[bus.mem_addr[14:2]];
        rd_q2 <= rd_q1;
    end
    assign bus.mem_rdata = rd_q2;

    int          n_mem_en   = 0;
    int          n_done     = 0;
    int          en_viol    = 0;
    int          align_viol = 0;
    int          stall_viol = 0;
    int          n_stall    = 0;
    int          since_en   = 100;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_last  = 1'b0;
    logic [31:0] got_q [$];
    logic        got_last [$];

    always @(negedge aclk) begin
        if (rst) begin
            prev_stall <= 1'b0;
            since_en   <= 100;
        end else begin
            if (bus.mem_en) begin
                n_mem_en <= n_mem_en + 1;
                if (since_en < RD_LAT) en_viol <= en_viol + 1;
                if (bus.mem_addr[1:0] != 2'b00) align_viol <= align_viol + 1;
                since_en <= 0;
            end else if (since_en < 100) begin
                since_en <= since_en + 1;
            end
            if (frame_done) n_done <= n_done + 1;
            if (prev_stall && (!bus.m_axis_tvalid || bus.m_axis_tdata != prev_data ||
                               bus.m_axis_tlast != prev_last))
                stall_viol <= stall_viol + 1;
            if (bus.m_axis_tvalid && !bus.m_axis_tready) n_stall <= n_stall + 1;
            prev_stall <= bus.m_axis_tvalid && !bus.m_axis_tready;
            prev_data  <= bus.m_axis_tdata;
            prev_last  <= bus.m_axis_tlast;
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                got_q.push_back(bus.m_axis_tdata);
                got_last.push_back(bus.m_axis_tlast);
            end
        end
    end

    logic stall_en = 1'b0;

    initial begin
        logic [3:0] pat;
        int         idx;
        pat = 4'b1001;
        idx = 0;
        bus.m_axis_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            if (stall_en) begin
                bus.m_axis_tready = pat[idx];
                idx = (idx + 1) % 4;
            end else begin
                bus.m_axis_tready = 1'b1;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic load_frame(input logic [31:0] id, input logic [31:0] sum);
        mem[0] = id;
        mem[1] = sum;
        mem[4] = D0;
        mem[5] = D1;
        mem[6] = D2;
    endtask

    task automatic run_frame(input string tag);
        int d0;
        int t;
        d0 = n_done;
        t  = 0;
        trigger = 1'b1;
        while (n_done == d0 && t < 400) begin
            tick(1);
            t++;
        end
        check_eq({tag, " done_seen"}, 32'(n_done != d0), 32'd1);
        trigger = 1'b0;
        tick(3);
    endtask

    task automatic check_stream(input string tag, input int start, input logic [31:0] exp[$]);
        check_eq({tag, " words"}, 32'(got_q.size() - start), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (start + i < got_q.size()) begin
                check_eq($sformatf("%s w%0d", tag, i), got_q[start + i], exp[i]);
                check_eq($sformatf("%s last%0d", tag, i), 32'(got_last[start + i]),
                         32'(i == exp.size() - 1));
            end
        end
    endtask

    initial begin
        int s;
        int e;
        int d;
        int t;
        int lasts;
        rst     = 1'b1;
        trigger = 1'b0;
        for (int i = 0; i < 8192; i++) mem[i] = '0;
        tick(3);
        check_eq("rst tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        check_eq("rst tlast", 32'(bus.m_axis_tlast), 32'd0);
        check_eq("rst tdata", bus.m_axis_tdata, 32'd0);
        check_eq("rst mem_en", 32'(bus.mem_en), 32'd0);
        check_eq("rst mem_addr", 32'(bus.mem_addr), 32'd0);
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst frame_done", 32'(frame_done), 32'd0);
        check_eq("rst id_error", 32'(id_error), 32'd0);
        check_eq("rst word_count", 32'(word_count), 32'd0);
        rst = 1'b0;
        tick(2);

        // Three-word frame, tready always high
        load_frame(GOOD_ID, SUM3);
        s = got_q.size(); e = n_mem_en; d = n_done;
        run_frame("fa");
        check_stream("fa", s, '{GOOD_ID, SUM3, D0, D1, D2});
        check_eq("fa word_count", 32'(word_count), 32'd3);
        check_eq("fa id_error", 32'(id_error), 32'd0);
        check_eq("fa done_pulses", 32'(n_done - d), 32'd1);
        check_eq("fa mem_reads", 32'(n_mem_en - e), 32'd5);

        // Empty frame: summary carries tlast
        load_frame(GOOD_ID, SUM0);
        s = got_q.size(); e = n_mem_en; d = n_done;
        run_frame("f0");
        check_stream("f0", s, '{GOOD_ID, SUM0});
        check_eq("f0 word_count", 32'(word_count), 32'd0);
        check_eq("f0 done_pulses", 32'(n_done - d), 32'd1);
        check_eq("f0 mem_reads", 32'(n_mem_en - e), 32'd2);

        // Bad ID: dropped, nothing streamed
        load_frame(BAD_ID, SUM3);
        s = got_q.size(); e = n_mem_en; d = n_done;
        run_frame("fbad");
        check_eq("fbad words", 32'(got_q.size() - s), 32'd0);
        check_eq("fbad id_error", 32'(id_error), 32'd1);
        check_eq("fbad word_count", 32'(word_count), 32'd0);
        check_eq("fbad done_pulses", 32'(n_done - d), 32'd1);
        check_eq("fbad mem_reads", 32'(n_mem_en - e), 32'd2);

        // Next good trigger clears id_error on acceptance
        load_frame(GOOD_ID, SUM3);
        s = got_q.size();
        trigger = 1'b1;
        tick(2);
        check_eq("clr busy", 32'(busy), 32'd1);
        check_eq("clr id_error", 32'(id_error), 32'd0);
        run_frame("fclr");
        check_stream("fclr", s, '{GOOD_ID, SUM3, D0, D1, D2});
        check_eq("fclr id_error", 32'(id_error), 32'd0);

        // Back-pressure with tready pattern 1-0-0-1
        stall_en = 1'b1;
        s = got_q.size(); d = n_stall;
        run_frame("fst");
        stall_en = 1'b0;
        tick(2);
        check_stream("fst", s, '{GOOD_ID, SUM3, D0, D1, D2});
        check_eq("fst stalls_seen", 32'(n_stall > d), 32'd1);
        check_eq("fst stable_while_stalled", 32'(stall_viol), 32'd0);

        // Held trigger with a second edge while busy: one frame only
        s = got_q.size(); d = n_done;
        trigger = 1'b1;
        tick(10);
        trigger = 1'b0;
        tick(1);
        trigger = 1'b1;
        tick(89);
        trigger = 1'b0;
        tick(20);
        check_eq("hold done_pulses", 32'(n_done - d), 32'd1);
        check_stream("hold", s, '{GOOD_ID, SUM3, D0, D1, D2});

        // Reset while the second data word is on the bus
        s = got_q.size();
        t = 0;
        trigger = 1'b1;
        while (!(bus.m_axis_tvalid && bus.m_axis_tdata == D1) && t < 200) begin
            tick(1);
            t++;
        end
        check_eq("mid reached_k1", 32'(t < 200), 32'd1);
        rst = 1'b1;
        trigger = 1'b0;
        #1;
        check_eq("mid tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        check_eq("mid mem_en", 32'(bus.mem_en), 32'd0);
        check_eq("mid tdata", bus.m_axis_tdata, 32'd0);
        check_eq("mid busy", 32'(busy), 32'd0);
        check_eq("mid word_count", 32'(word_count), 32'd0);
        check_eq("mid partial_words", 32'(got_q.size() - s), 32'd3);
        lasts = 0;
        for (int i = s; i < got_q.size(); i++) lasts += int'(got_last[i]);
        check_eq("mid partial_tlast", 32'(lasts), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(2);
        s = got_q.size();
        run_frame("fpost");
        check_stream("fpost", s, '{GOOD_ID, SUM3, D0, D1, D2});
        check_eq("fpost word_count", 32'(word_count), 32'd3);

        check_eq("read_overlap", 32'(en_viol), 32'd0);
        check_eq("addr_align", 32'(align_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
